// File: rtl/unit_pkg.sv
// Shared types and helpers for the unit_nto1 binary neuron.
package unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_BWD,
        S_DONE
    } unit_state_t;

    localparam int unsigned POP_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational count of matching bits between one input slice and one weight slice.
module xnor_popcount
    import unit_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic [LANES-1:0]             fin_slice,
    input  logic [LANES-1:0]             w_slice,
    output logic [$clog2(LANES+1)-1:0]   match_cnt
);

    localparam int unsigned CW = $clog2(LANES + 1);

    logic [POP_MAX_W-1:0] match_vec;

    always_comb begin
        match_vec              = '0;
        match_vec[LANES-1:0]   = ~(fin_slice ^ w_slice);
        match_cnt              = CW'(popcount(match_vec));
    end

endmodule

// File: rtl/unit_nto1.sv
// N-input binary neuron: lane-serial XNOR-popcount forward pass, error backward pass
// with optional weight update, and a serial weight daisy chain.
module unit_nto1
    import unit_pkg::*;
#(
    parameter int unsigned N_IN   = 8,
    parameter int unsigned LANES  = 2,
    parameter int unsigned THRESH = N_IN / 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            oscillator,
    input  logic            fd_prop,
    input  logic            bk_prop,
    input  logic            learn_en,
    input  logic [N_IN-1:0] fin,
    input  logic            bin,
    input  logic            w_shift_en,
    input  logic            w_shift_in,
    output logic            control_out,
    output logic            fout,
    output logic            fout_valid,
    output logic [N_IN-1:0] bout,
    output logic            bout_valid,
    output logic            busy
);

    localparam int unsigned P  = N_IN / LANES;
    localparam int unsigned AW = $clog2(N_IN + 1);
    localparam int unsigned IW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned CW = $clog2(LANES + 1);
    localparam logic [AW-1:0] THR = AW'(THRESH);

    unit_state_t       state, state_next;
    logic [IW-1:0]     idx;
    logic [AW-1:0]     acc;
    logic [N_IN-1:0]   fin_q;
    logic [N_IN-1:0]   w;
    logic              bin_q;
    logic              learn_q;
    logic [N_IN-1:0]   bout_work;

    logic              fd_go, bk_go, last;
    logic [31:0]       base;
    logic [LANES-1:0]  fin_slice, w_slice;
    logic [CW-1:0]     match_cnt;
    logic [AW-1:0]     acc_sum;
    logic              fwd_result;
    logic              do_learn;
    logic [N_IN-1:0]   bout_merged;

    assign base      = 32'(idx) * LANES;
    assign fin_slice = fin_q[base +: LANES];
    assign w_slice   = w[base +: LANES];
    assign last      = (idx == IW'(P - 1));

    xnor_popcount #(.LANES(LANES)) u_pop (
        .fin_slice (fin_slice),
        .w_slice   (w_slice),
        .match_cnt (match_cnt)
    );

    assign acc_sum     = acc + AW'(match_cnt);
    assign fwd_result  = (acc_sum > THR) | ((acc_sum == THR) & oscillator);
    assign do_learn    = learn_q & (bin_q != fout);
    assign busy        = (state != S_IDLE);
    assign control_out = w[N_IN-1];

    // Backward bits accumulate in a shadow so bout only changes when the pass completes.
    always_comb begin
        bout_merged                   = bout_work;
        bout_merged[base +: LANES]    = ~(w_slice ^ {LANES{bin_q}});
    end

    always_comb begin
        state_next = state;
        fd_go      = 1'b0;
        bk_go      = 1'b0;
        case (state)
            S_IDLE: begin
                if (fd_prop) begin
                    fd_go      = 1'b1;
                    state_next = S_FWD;
                end else if (bk_prop) begin
                    bk_go      = 1'b1;
                    state_next = S_BWD;
                end
            end
            S_FWD:   if (last) state_next = S_DONE;
            S_BWD:   if (last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= S_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            idx        <= '0;
            acc        <= '0;
            fin_q      <= '0;
            w          <= '1;
            bin_q      <= 1'b0;
            learn_q    <= 1'b0;
            bout_work  <= '0;
            fout       <= 1'b0;
            fout_valid <= 1'b0;
            bout       <= '0;
            bout_valid <= 1'b0;
        end else begin
            fout_valid <= 1'b0;
            bout_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fd_go) begin
                        fin_q <= fin;
                        acc   <= '0;
                        idx   <= '0;
                    end else if (bk_go) begin
                        bin_q   <= bin;
                        learn_q <= learn_en;
                        idx     <= '0;
                    end else if (w_shift_en) begin
                        w <= {w[N_IN-2:0], w_shift_in};
                    end
                end
                S_FWD: begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                    if (last) begin
                        fout       <= fwd_result;
                        fout_valid <= 1'b1;
                    end
                end
                S_BWD: begin
                    bout_work <= bout_merged;
                    idx       <= idx + 1'b1;
                    if (do_learn) w[base +: LANES] <= ~(fin_slice ^ {LANES{bin_q}});
                    if (last) begin
                        bout       <= bout_merged;
                        bout_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
